gaussian_scan_sched: RTL and testbench
======================================

Name: gaussian_scan_sched

Overview:
Scan scheduler for the 7x7 Gaussian datapath: on a start pulse it walks every valid window position of a ROW x COL frame, issuing read requests to the original-image DRAM. It tracks each request through the fixed-latency read+core pipeline and emits the matching centre-pixel write address downstream. Downstream backpressure (out_ready) freezes the whole pipeline through core_en. It reports busy/done to the frame-level top.

Parameters:
ROW, 720, frame height in pixels
COL, 1280, frame width in pixels
WIDTH, 7, square window size (odd); HALO = (WIDTH-1)/2 is derived
ADDRLEN, 21, pixel address width; ROW*COL must be <= 2**ADDRLEN (elaboration check)
PIPE_LAT, 3, cycles from ren to result valid (DRAM read + core), >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle frame start request; honoured only in IDLE
abort  in  1  synchronous abort; flushes and returns to IDLE
ren  out  1  DRAM read enable, one window per cycle
raddr  out  ADDRLEN  top-left pixel address of the issued window
core_en  out  1  pipeline advance enable for DRAM read stage and core
out_valid  out  1  result at pipeline tail valid
out_ready  in  1  downstream buffer accepts result
wen  out  1  write strobe to output buffer = out_valid & out_ready
waddr  out  ADDRLEN  centre-pixel address of the tail result
busy  out  1  high in SCAN and DRAIN
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst=0): state IDLE; ren, core_en-pipeline valids, out_valid, wen, busy, done = 0; raddr, waddr, row/col counters = 0.
- advance = ~(out_valid & ~out_ready); core_en = advance. When advance=0, counters, valid pipe and address pipe hold.
- States: IDLE -> SCAN on start; SCAN -> DRAIN on issue of the last window; DRAIN -> DONE when valid pipe empty and out_valid=0; DONE -> IDLE unconditionally (done=1 for this one cycle only).
- abort in any state: next cycle state IDLE, all valid bits cleared, counters cleared, no done pulse. abort wins over start in the same cycle.
- start outside IDLE ignored (includes DONE cycle).
- Issue: ren = (state==SCAN) & advance; raddr = row_base + col, valid in the ren cycle.
- Scan order row-major: col 0..COL-WIDTH, row 0..ROW-WIDTH inclusive; total (ROW-WIDTH+1)*(COL-WIDTH+1) windows (909,636 at defaults).
- No multiplier: row_base += COL on row wrap; col resets to 0.
- Per issue, push {1, raddr + HALO*COL + HALO} into a PIPE_LAT-deep valid/address delay line shifting only on advance; tail gives out_valid/waddr. A result issued at cycle t is at the tail at t+PIPE_LAT if no stalls.
- Each result is presented until accepted; wen never asserts twice for one result.
- Arithmetic unsigned ADDRLEN bits; never wraps given the elaboration check.
- busy = (state==SCAN)|(state==DRAIN).

Decomposition:
- Package gaussian_pkg: state enum {IDLE,SCAN,DRAIN,DONE}, ADDRLEN-wide address typedef, HALO function/localparam.
- Sub-module scan_pipe: parameterised PIPE_LAT-deep valid+address delay line with shift enable and synchronous flush.

Test Plan:
- ROW=10,COL=12,WIDTH=3,PIPE_LAT=3, out_ready=1, start at cycle 0 -> ren cycles 1..80; first raddr 0, waddr 13; last raddr 93, waddr 106; 80 wen; done exactly at cycle 84; busy 1..83.
- Same config, out_ready=0 for 5 cycles while out_valid=1 -> ren, raddr, waddr frozen; no wen; no lost or duplicated address; total wen still 80.
- Row wrap: check issue after raddr 9 is raddr 12 (row 1, col 0) and waddr 25.
- abort asserted at issue #40 -> next cycle IDLE, out_valid=0, no done; a new start gives first raddr 0 again.
- start pulsed during SCAN and during the DONE cycle -> ignored, counters unaffected, single done.
- rst driven low mid-SCAN, asynchronously between edges -> all outputs 0 immediately; after release, IDLE until start.

Source files
------------

// File: rtl/gaussian_scan_sched_pkg.sv
// Shared types and helpers for the Gaussian scan scheduler.
package gaussian_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned ADDRLEN_DEF = 21;

    typedef logic [ADDRLEN_DEF-1:0] addr_t;

    function automatic int unsigned halo(input int unsigned width);
        return (width - 1) / 2;
    endfunction

endpackage

// File: rtl/gaussian_scan_sched_if.sv
// DRAM read-request and result write-out handshake of the scan scheduler.
interface gaussian_scan_sched_if #(
    parameter int unsigned ADDRLEN = 21
);
    logic               ren;
    logic [ADDRLEN-1:0] raddr;
    logic               core_en;
    logic               out_valid;
    logic               out_ready;
    logic               wen;
    logic [ADDRLEN-1:0] waddr;

    modport master (
        output ren, raddr, core_en, out_valid, wen, waddr,
        input  out_ready
    );

    modport slave (
        input  ren, raddr, core_en, out_valid, wen, waddr,
        output out_ready
    );
endinterface

// File: rtl/gaussian_scan_sched_scan_pipe.sv
// Fixed-latency valid/address delay line tracking reads through DRAM + core.
module scan_pipe #(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned ADDRLEN  = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [ADDRLEN-1:0] in_addr,
    output logic               out_valid,
    output logic [ADDRLEN-1:0] out_addr,
    output logic               empty_next
);

    logic [PIPE_LAT-1:0] vld_q;
    logic [ADDRLEN-1:0]  adr_q [PIPE_LAT];
    logic                body_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (shift_en) begin
            vld_q[0] <= in_valid;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                adr_q[i] <= '0;
            end
        end else if (shift_en) begin
            adr_q[0] <= in_addr;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    // Emptiness as it will be after this edge: the tail leaves whenever we shift.
    always_comb begin
        body_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < PIPE_LAT; i++) begin
            body_busy = body_busy | vld_q[i];
        end
        empty_next = shift_en ? ~(body_busy | in_valid) : ~(|vld_q);
    end

    assign out_valid = vld_q[PIPE_LAT-1];
    assign out_addr  = adr_q[PIPE_LAT-1];

endmodule

// File: rtl/gaussian_scan_sched.sv
// Walks every valid WIDTHxWIDTH window of a ROWxCOL frame, issuing DRAM reads
// and emitting the matching centre-pixel write address after PIPE_LAT cycles.
module gaussian_scan_sched
    import gaussian_pkg::*;
#(
    parameter int unsigned ROW      = 720,
    parameter int unsigned COL      = 1280,
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned ADDRLEN  = 21,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    gaussian_scan_sched_if.master bus,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned HALO = halo(WIDTH);

    localparam logic [ADDRLEN-1:0] ROW_LAST   = ADDRLEN'(ROW - WIDTH);
    localparam logic [ADDRLEN-1:0] COL_LAST   = ADDRLEN'(COL - WIDTH);
    localparam logic [ADDRLEN-1:0] COL_STEP   = ADDRLEN'(COL);
    localparam logic [ADDRLEN-1:0] CENTER_OFS = ADDRLEN'(HALO * COL + HALO);
    localparam logic [ADDRLEN-1:0] ONE        = ADDRLEN'(1);

    if ((longint'(ROW) * longint'(COL)) > (longint'(1) << ADDRLEN)) begin : g_addr_check
        $error("gaussian_scan_sched: ROW*COL does not fit in ADDRLEN bits");
    end
    if ((WIDTH % 2) == 0 || WIDTH > ROW || WIDTH > COL || PIPE_LAT < 1) begin : g_param_check
        $error("gaussian_scan_sched: WIDTH must be odd and fit the frame, PIPE_LAT >= 1");
    end

    state_t             state_q, state_d;
    logic [ADDRLEN-1:0] row_q, col_q, base_q;
    logic [ADDRLEN-1:0] rd_addr;
    logic               advance;
    logic               issue;
    logic               last_win;
    logic               pipe_valid;
    logic [ADDRLEN-1:0] pipe_addr;
    logic               pipe_empty_next;

    assign advance  = ~(pipe_valid & ~bus.out_ready);
    assign last_win = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign rd_addr  = base_q + col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SCAN;
                SCAN:    if (issue && last_win) state_d = DRAIN;
                DRAIN:   if (pipe_empty_next) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        issue = (state_q == SCAN) && advance;
        busy  = (state_q == SCAN) || (state_q == DRAIN);
        done  = (state_q == DONE);
    end

    // Row base accumulates COL per wrapped row, avoiding a row*COL multiply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else if (abort || state_q == IDLE) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else if (issue) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                    row_q  <= '0;
                    base_q <= '0;
                end else begin
                    row_q  <= row_q + ONE;
                    base_q <= base_q + COL_STEP;
                end
            end else begin
                col_q <= col_q + ONE;
            end
        end
    end

    scan_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .ADDRLEN  (ADDRLEN)
    ) u_scan_pipe (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (advance),
        .flush      (abort),
        .in_valid   (issue),
        .in_addr    (rd_addr + CENTER_OFS),
        .out_valid  (pipe_valid),
        .out_addr   (pipe_addr),
        .empty_next (pipe_empty_next)
    );

    assign bus.ren       = issue;
    assign bus.raddr     = rd_addr;
    assign bus.core_en   = advance;
    assign bus.out_valid = pipe_valid;
    assign bus.wen       = pipe_valid & bus.out_ready;
    assign bus.waddr     = pipe_addr;

endmodule

// File: tb/tb_gaussian_scan_sched.sv
// Directed bench for gaussian_scan_sched on a 10x12 frame, 3x3 window, latency 3.
module tb_gaussian_scan_sched;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;

    int vectors;
    int miscompares;

    int rq[$];
    int wq[$];
    int ren_first, ren_last, wen_first;
    int done_cnt, done_cyc;
    int busy_cnt, busy_first, busy_last;

    gaussian_scan_sched_if #(.ADDRLEN(21)) bus ();

    gaussian_scan_sched #(
        .ROW      (10),
        .COL      (12),
        .WIDTH    (3),
        .ADDRLEN  (21),
        .PIPE_LAT (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window k sits at row k/10, col k%10 of a 12-pixel-wide frame.
    function automatic int exp_raddr(input int k);
        return (k / 10) * 12 + (k % 10);
    endfunction

    task automatic chk_seq(input string tag);
        for (int k = 0; k < rq.size(); k++) chk({tag, "_raddr"}, rq[k], exp_raddr(k));
        for (int k = 0; k < wq.size(); k++) chk({tag, "_waddr"}, wq[k], exp_raddr(k) + 13);
    endtask

    task automatic step_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_ren"}, bus.ren, 0);
            chk({tag, "_done"}, done, 0);
        end
    endtask

    // Called at the sample point of an idle cycle; that cycle becomes cycle 0 with start high.
    task automatic run_frame(input int ncyc, input int stall_at, input int stall_len,
                             input int abort_at, input int xs_a, input int xs_b);
        logic [31:0] hold_r, hold_w;
        hold_r = '0;
        hold_w = '0;
        rq.delete(); wq.delete();
        ren_first = -1; ren_last = -1; wen_first = -1;
        done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        start = 1'b1; abort = 1'b0; bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == xs_a) || (cyc == xs_b);
            abort = (cyc == abort_at);
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (cyc >= stall_at && cyc < stall_at + stall_len) begin
                if (cyc == stall_at) begin
                    hold_r = 32'(bus.raddr);
                    hold_w = 32'(bus.waddr);
                    chk("stall_out_valid", bus.out_valid, 1);
                end
                chk("stall_ren", bus.ren, 0);
                chk("stall_wen", bus.wen, 0);
                chk("stall_core_en", bus.core_en, 0);
                chk("stall_raddr", bus.raddr, hold_r);
                chk("stall_waddr", bus.waddr, hold_w);
            end
            if (bus.ren) begin
                rq.push_back(int'(bus.raddr));
                if (ren_first < 0) ren_first = cyc;
                ren_last = cyc;
            end
            if (bus.wen) begin
                wq.push_back(int'(bus.waddr));
                if (wen_first < 0) wen_first = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.out_ready = 1'b1;

        #1;
        chk("rst_ren", bus.ren, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_wen", bus.wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_raddr", bus.raddr, 0);
        chk("rst_waddr", bus.waddr, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        step_idle("idle0", 3);
        chk("idle_core_en", bus.core_en, 1);

        // Nominal frame, out_ready held high.
        run_frame(95, -1, 0, -1, -1, -1);
        chk("nom_ren_count", rq.size(), 80);
        chk("nom_ren_first", ren_first, 1);
        chk("nom_ren_last", ren_last, 80);
        chk("nom_first_raddr", rq[0], 0);
        chk("nom_last_raddr", rq[79], 93);
        chk("nom_wrap_raddr", rq[10], 12);
        chk("nom_wen_count", wq.size(), 80);
        chk("nom_wen_first", wen_first, 4);
        chk("nom_first_waddr", wq[0], 13);
        chk("nom_wrap_waddr", wq[10], 25);
        chk("nom_last_waddr", wq[79], 106);
        chk("nom_done_count", done_cnt, 1);
        chk("nom_done_cyc", done_cyc, 84);
        chk("nom_busy_first", busy_first, 1);
        chk("nom_busy_last", busy_last, 83);
        chk("nom_busy_count", busy_cnt, 83);
        chk_seq("nom");
        step_idle("idle1", 2);

        // Five-cycle downstream stall starting at cycle 20.
        run_frame(100, 20, 5, -1, -1, -1);
        chk("stl_ren_count", rq.size(), 80);
        chk("stl_ren_last", ren_last, 85);
        chk("stl_wen_count", wq.size(), 80);
        chk("stl_wen_first", wen_first, 4);
        chk("stl_done_count", done_cnt, 1);
        chk("stl_done_cyc", done_cyc, 89);
        chk_seq("stl");
        step_idle("idle2", 2);

        // Abort in the cycle of issue #40.
        run_frame(40, -1, 0, 40, -1, -1);
        chk("abt_ren_count", rq.size(), 40);
        chk("abt_last_raddr", rq[39], 45);
        chk_seq("abt");
        chk("abt_busy", busy, 0);
        chk("abt_out_valid", bus.out_valid, 0);
        chk("abt_ren", bus.ren, 0);
        chk("abt_wen", bus.wen, 0);
        chk("abt_done", done, 0);
        step_idle("abt_idle", 6);

        // Restart after abort; stray starts during SCAN and in the DONE cycle.
        run_frame(100, -1, 0, -1, 30, 84);
        chk("xs_ren_first", ren_first, 1);
        chk("xs_first_raddr", rq[0], 0);
        chk("xs_ren_count", rq.size(), 80);
        chk("xs_ren_last", ren_last, 80);
        chk("xs_wen_count", wq.size(), 80);
        chk("xs_done_count", done_cnt, 1);
        chk("xs_done_cyc", done_cyc, 84);
        chk_seq("xs");
        step_idle("xs_idle", 4);

        // Asynchronous reset in the middle of a scan.
        run_frame(30, -1, 0, -1, -1, -1);
        chk("ar_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ren", bus.ren, 0);
        chk("ar_raddr", bus.raddr, 0);
        chk("ar_out_valid", bus.out_valid, 0);
        chk("ar_wen", bus.wen, 0);
        chk("ar_waddr", bus.waddr, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        #2;
        rst = 1'b1;
        step_idle("ar_idle", 5);
        run_frame(5, -1, 0, -1, -1, -1);
        chk("ar_restart_first", ren_first, 1);
        chk("ar_restart_raddr", rq[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
